// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshakes and fifo write port shared by the arbiter and its environment.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  fifo_full;
  logic                  fifo_write_en;
  logic [DATA_WIDTH-1:0] fifo_data_in;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, fifo_full,
    output req0_ready, req1_ready, fifo_write_en, fifo_data_in
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, fifo_full,
    input  req0_ready, req1_ready, fifo_write_en, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between two byte producers,
// issuing isolated single-cycle write_en pulses (IDLE -> WRITE -> GAP).
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  fifo_wr_arbiter_if.master      bus,
  output logic                   busy,
  output logic                   last_grant,
  output logic [COUNT_WIDTH-1:0] count0,
  output logic [COUNT_WIDTH-1:0] count1
);

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t state;
  state_t state_nxt;
  logic   grant_vld;
  logic   grant_idx;

  // Arbitration: only in IDLE with room in the fifo; readys are held low during reset.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    if (state == IDLE && !bus.fifo_full && reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_idx = ~last_grant;
      end else if (bus.req0_valid) begin
        grant_vld = 1'b1;
        grant_idx = 1'b0;
      end else if (bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_idx = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = WRITE;
      WRITE:   state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = grant_vld && !grant_idx;
    bus.req1_ready = grant_vld && grant_idx;
    busy           = (state != IDLE);
  end

  // A grant always carries a valid, so a grant is a transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.fifo_write_en <= 1'b0;
      bus.fifo_data_in  <= '0;
      last_grant        <= 1'b1;
      count0            <= '0;
      count1            <= '0;
    end else begin
      bus.fifo_write_en <= grant_vld;
      if (grant_vld) begin
        last_grant <= grant_idx;
        if (grant_idx) begin
          bus.fifo_data_in <= bus.req1_data;
          count1           <= count1 + COUNT_WIDTH'(1);
        end else begin
          bus.fifo_data_in <= bus.req0_data;
          count0           <= count0 + COUNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a 16-deep fifo model for the fill test.
module tb_fifo_wr_arbiter;

  logic       clock;
  logic       reset;
  logic       busy;
  logic       last_grant;
  logic [3:0] count0;
  logic [3:0] count1;

  logic       full_force;
  logic       model_en;
  int         fcnt;
  int         ovf;
  logic [7:0] mem [16];
  int         pulses;
  int         checks;
  int         errors;

  fifo_wr_arbiter_if #(.DATA_WIDTH(8)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.master),
    .busy       (busy),
    .last_grant (last_grant),
    .count0     (count0),
    .count1     (count1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.fifo_full = model_en ? (fcnt == 16) : full_force;

  // fifo model: stores on each write_en pulse while not full
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      fcnt <= 0;
      ovf  <= 0;
    end else if (model_en && bus.fifo_write_en) begin
      if (fcnt < 16) begin
        mem[fcnt] <= bus.fifo_data_in;
        fcnt      <= fcnt + 1;
      end else begin
        ovf <= ovf + 1;
      end
    end
  end

  always @(posedge clock) if (bus.fifo_write_en) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int accepted;
    int base;
    logic got;
    checks = 0; errors = 0; pulses = 0;
    reset = 1'b0; full_force = 1'b0; model_en = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00;

    // reset state
    tick();
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_wen",    32'(bus.fifo_write_en), 0);
    chk("rst_data",   32'(bus.fifo_data_in), 0);
    chk("rst_last",   32'(last_grant), 1);
    chk("rst_count0", 32'(count0), 0);
    chk("rst_count1", 32'(count1), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_ready0", 32'(bus.req0_ready), 0);
    bus.req0_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // single requester 0 transfer
    bus.req0_valid = 1'b1; bus.req0_data = 8'hA5;
    #1;
    chk("t1_ready0", 32'(bus.req0_ready), 1);
    chk("t1_ready1", 32'(bus.req1_ready), 0);
    tick();
    bus.req0_valid = 1'b0;
    chk("t1_wen",        32'(bus.fifo_write_en), 1);
    chk("t1_data",       32'(bus.fifo_data_in), 32'hA5);
    chk("t1_count0",     32'(count0), 1);
    chk("t1_last",       32'(last_grant), 0);
    chk("t1_busy_write", 32'(busy), 1);
    chk("t1_ready_wr",   32'(bus.req0_ready), 0);
    tick();
    chk("t1_gap_wen",  32'(bus.fifo_write_en), 0);
    chk("t1_gap_busy", 32'(busy), 1);
    chk("t1_gap_data", 32'(bus.fifo_data_in), 32'hA5);
    tick();
    chk("t1_idle_busy", 32'(busy), 0);

    // fresh reset, then both requesters held valid
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    bus.req0_valid = 1'b1; bus.req0_data = 8'h11;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_ready0", 32'(bus.req0_ready), (i % 2 == 0) ? 1 : 0);
      chk("t2_ready1", 32'(bus.req1_ready), (i % 2 == 1) ? 1 : 0);
      tick();
      chk("t2_wen",  32'(bus.fifo_write_en), 1);
      chk("t2_data", 32'(bus.fifo_data_in), (i % 2 == 0) ? 32'h11 : 32'h22);
      tick();
      chk("t2_gap_wen", 32'(bus.fifo_write_en), 0);
      tick();
    end
    chk("t2_count0", 32'(count0), 2);
    chk("t2_count1", 32'(count1), 2);
    chk("t2_last",   32'(last_grant), 1);

    // fifo full blocks arbitration
    full_force = 1'b1;
    #1;
    chk("t3_ready0_full", 32'(bus.req0_ready), 0);
    chk("t3_ready1_full", 32'(bus.req1_ready), 0);
    repeat (10) begin
      tick();
      chk("t3_ready0", 32'(bus.req0_ready), 0);
      chk("t3_ready1", 32'(bus.req1_ready), 0);
      chk("t3_wen",    32'(bus.fifo_write_en), 0);
      chk("t3_busy",   32'(busy), 0);
    end
    chk("t3_last", 32'(last_grant), 1);
    full_force = 1'b0;
    #1;
    chk("t3_resume_ready0", 32'(bus.req0_ready), 1);
    chk("t3_resume_ready1", 32'(bus.req1_ready), 0);
    tick();
    chk("t3_wen_after", 32'(bus.fifo_write_en), 1);
    chk("t3_data_after", 32'(bus.fifo_data_in), 32'h11);
    chk("t3_count0", 32'(count0), 3);

    // reset asserted during WRITE
    reset = 1'b0;
    #1;
    chk("t4_wen",    32'(bus.fifo_write_en), 0);
    chk("t4_count0", 32'(count0), 0);
    chk("t4_count1", 32'(count1), 0);
    chk("t4_busy",   32'(busy), 0);
    chk("t4_last",   32'(last_grant), 1);
    tick();
    chk("t4_ready0_rst", 32'(bus.req0_ready), 0);
    chk("t4_ready1_rst", 32'(bus.req1_ready), 0);
    reset = 1'b1;
    #1;
    chk("t4_first_ready0", 32'(bus.req0_ready), 1);
    chk("t4_first_ready1", 32'(bus.req1_ready), 0);

    // 16 requester-1 words wrap the 4-bit counter
    bus.req0_valid = 1'b0;
    base = pulses;
    for (int i = 0; i < 16; i++) begin
      bus.req1_data = 8'h30 + 8'(i);
      #1;
      chk("t5_ready1",   32'(bus.req1_ready), 1);
      chk("t5_wen_pre",  32'(bus.fifo_write_en), 0);
      tick();
      chk("t5_wen",      32'(bus.fifo_write_en), 1);
      chk("t5_data",     32'(bus.fifo_data_in), 32'h30 + i);
      tick();
      chk("t5_wen_post", 32'(bus.fifo_write_en), 0);
      tick();
    end
    chk("t5_count1", 32'(count1), 0);
    chk("t5_count0", 32'(count0), 0);
    chk("t5_pulses", 32'(pulses - base), 16);
    chk("t5_last",   32'(last_grant), 1);
    bus.req1_valid = 1'b0;

    // 20 words into a 16-deep fifo model
    reset = 1'b0;
    #1;
    reset = 1'b1;
    model_en = 1'b1;
    tick();
    accepted = 0;
    for (int c = 0; c < 100; c++) begin
      bus.req0_valid = (accepted < 20);
      bus.req0_data  = 8'h40 + 8'(accepted);
      #1;
      got = bus.req0_ready;
      chk("t6_ready_while_full", 32'(bus.req0_ready & bus.fifo_full), 0);
      tick();
      if (got) accepted++;
    end
    bus.req0_valid = 1'b0;
    chk("t6_accepted", 32'(accepted), 16);
    chk("t6_stored",   32'(fcnt), 16);
    chk("t6_overflow", 32'(ovf), 0);
    for (int i = 0; i < 16; i++) chk("t6_order", 32'(mem[i]), 32'h40 + i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
